// File: rtl/round_key_server.sv
// Round-key store and sequencer for the masked AES AddRoundKey stage.
// Keys are loaded in schedule order and served forward or reverse over valid/ready.
module round_key_server #(
    parameter int d  = 2,
    parameter int NR = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [3:0][3:0][0:7+d] wr_key_i,
    input  logic                   start_i,
    input  logic                   dir_i,
    output logic                   key_valid_o,
    input  logic                   key_ready_i,
    output logic [3:0][3:0][0:7+d] key_o,
    output logic [3:0]             round_o,
    output logic                   last_o,
    output logic                   loaded_o,
    output logic                   busy_o
);

    typedef logic [3:0][3:0][0:7+d] key_t;
    typedef enum logic [1:0] {S_LOAD, S_IDLE, S_SERVE} state_e;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    state_e     state_q;
    logic [3:0] wcnt_q;
    logic       dir_q;
    logic       key_valid_q;
    key_t       key_q;
    logic [3:0] round_q;
    logic       last_q;
    logic       loaded_q;
    logic       busy_q;

    key_t       mem [0:NR];

    logic       wr_fire;
    logic [3:0] waddr;
    logic       ndir;
    logic [3:0] nidx_d;
    logic       nlast_d;

    // A start request in IDLE takes priority, so the loader is held off that cycle.
    always_comb begin
        wr_ready_o = (state_q == S_LOAD) || (state_q == S_IDLE && !start_i);
        wr_fire    = wr_valid_i && wr_ready_o;
        waddr      = (state_q == S_IDLE) ? 4'd0 : wcnt_q;
        ndir       = (state_q == S_IDLE) ? dir_i : dir_q;
        if (state_q == S_IDLE)
            nidx_d = dir_i ? LAST_IDX : 4'd0;
        else
            nidx_d = dir_q ? (round_q - 4'd1) : (round_q + 4'd1);
        nlast_d    = ndir ? (nidx_d == 4'd0) : (nidx_d == LAST_IDX);
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire)
            mem[waddr] <= wr_key_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            wcnt_q      <= 4'd0;
            dir_q       <= 1'b0;
            key_valid_q <= 1'b0;
            key_q       <= '0;
            round_q     <= 4'd0;
            last_q      <= 1'b0;
            loaded_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (wr_fire) begin
                        wcnt_q <= wcnt_q + 4'd1;
                        if (wcnt_q == LAST_IDX) begin
                            state_q  <= S_IDLE;
                            loaded_q <= 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (start_i) begin
                        state_q     <= S_SERVE;
                        dir_q       <= dir_i;
                        busy_q      <= 1'b1;
                        key_valid_q <= 1'b1;
                        key_q       <= mem[nidx_d];
                        round_q     <= nidx_d;
                        last_q      <= nlast_d;
                    end else if (wr_valid_i) begin
                        // Reload restarts the schedule; word 0 is stored this cycle.
                        state_q  <= S_LOAD;
                        wcnt_q   <= 4'd1;
                        loaded_q <= 1'b0;
                    end
                end
                S_SERVE: begin
                    if (key_valid_q && key_ready_i) begin
                        if (last_q) begin
                            state_q     <= S_IDLE;
                            key_valid_q <= 1'b0;
                            key_q       <= '0;
                            round_q     <= 4'd0;
                            last_q      <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            key_q   <= mem[nidx_d];
                            round_q <= nidx_d;
                            last_q  <= nlast_d;
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign key_valid_o = key_valid_q;
    assign key_o       = key_q;
    assign round_o     = round_q;
    assign last_o      = last_q;
    assign loaded_o    = loaded_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_round_key_server.sv
// Directed/randomized bench for round_key_server against an array-and-queue key model.
module tb_round_key_server;

    localparam int D  = 2;
    localparam int NR = 10;
    localparam int BW = 8 + D;

    typedef logic [3:0][3:0][0:7+D] key_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid_i;
    logic       wr_ready_o;
    key_t       wr_key_i;
    logic       start_i;
    logic       dir_i;
    logic       key_valid_o;
    logic       key_ready_i;
    key_t       key_o;
    logic [3:0] round_o;
    logic       last_o;
    logic       loaded_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;

    key_t ref_mem [0:NR];

    round_key_server #(.d(D), .NR(NR)) dut (
        .clk(clk), .rst(rst),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_key_i(wr_key_i),
        .start_i(start_i), .dir_i(dir_i),
        .key_valid_o(key_valid_o), .key_ready_i(key_ready_i), .key_o(key_o),
        .round_o(round_o), .last_o(last_o), .loaded_o(loaded_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic key_t mk_key(input int r);
        key_t k;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                k[i][j] = {8'(r * 8'h11), {D{1'b0}}};
        return k;
    endfunction

    function automatic key_t rand_key();
        key_t k;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                k[i][j] = BW'($urandom);
        return k;
    endfunction

    // Loads NR+1 words; random=1 uses full-width random words including mask bits.
    // stall_at injects one start_i-only cycle after that word to prove start is ignored in LOAD.
    task automatic load_all(input bit random, input int stall_at);
        key_t k;
        for (int r = 0; r <= NR; r++) begin
            k = random ? rand_key() : mk_key(r);
            wr_valid_i = 1'b1;
            wr_key_i   = k;
            #1;
            check("wr_ready_load", 256'(wr_ready_o), 256'(1));
            tick();
            ref_mem[r] = k;
            check("loaded_during_load", 256'(loaded_o), 256'(r == NR));
            if (r == stall_at) begin
                wr_valid_i = 1'b0;
                start_i    = 1'b1;
                tick();
                start_i = 1'b0;
                check("start_ignored_busy", 256'(busy_o), 256'(0));
                check("start_ignored_valid", 256'(key_valid_o), 256'(0));
            end
        end
        wr_valid_i = 1'b0;
    endtask

    // Consumes one pass after start has been accepted. mode: 0 ready=1, 1 toggle, 2 random.
    task automatic serve_run(input bit dir, input int mode);
        int q[$];
        int cyc;
        for (int r = 0; r <= NR; r++) q.push_back(dir ? NR - r : r);
        cyc = 0;
        while (q.size() > 0 && cyc < 200) begin
            case (mode)
                0:       key_ready_i = 1'b1;
                1:       key_ready_i = (cyc % 2 == 0);
                default: key_ready_i = 1'($urandom_range(0, 1));
            endcase
            #1;
            check("serve_valid", 256'(key_valid_o), 256'(1));
            check("serve_round", 256'(round_o), 256'(q[0]));
            check("serve_key", 256'(key_o), 256'(ref_mem[q[0]]));
            check("serve_last", 256'(last_o), 256'(q.size() == 1));
            if (key_ready_i) void'(q.pop_front());
            tick();
            cyc++;
        end
        check("serve_timeout", 256'(q.size()), 256'(0));
        key_ready_i = 1'b0;
        check("end_valid", 256'(key_valid_o), 256'(0));
        check("end_key_zero", 256'(key_o), 256'(0));
        check("end_busy", 256'(busy_o), 256'(0));
        check("end_loaded", 256'(loaded_o), 256'(1));
    endtask

    task automatic start_pass(input bit dir);
        start_i = 1'b1;
        dir_i   = dir;
        tick();
        start_i = 1'b0;
        dir_i   = 1'b0;
    endtask

    initial begin
        int cyc;
        rst = 1'b1; wr_valid_i = 1'b0; wr_key_i = '0; start_i = 1'b0;
        dir_i = 1'b0; key_ready_i = 1'b0;
        tick(); tick();
        check("rst_wr_ready", 256'(wr_ready_o), 256'(1));
        check("rst_key_valid", 256'(key_valid_o), 256'(0));
        check("rst_key", 256'(key_o), 256'(0));
        check("rst_round", 256'(round_o), 256'(0));
        check("rst_last", 256'(last_o), 256'(0));
        check("rst_loaded", 256'(loaded_o), 256'(0));
        check("rst_busy", 256'(busy_o), 256'(0));
        rst = 1'b0;

        // Schedule-pattern keys, forward at full rate then reverse with stalls.
        load_all(1'b0, -1);
        start_pass(1'b0);
        serve_run(1'b0, 0);
        start_pass(1'b1);
        serve_run(1'b1, 1);

        // start_i and wr_valid_i together in IDLE: serve wins, storage untouched.
        start_i = 1'b1; dir_i = 1'b0; wr_valid_i = 1'b1; wr_key_i = rand_key();
        #1;
        check("start_vs_wr_ready", 256'(wr_ready_o), 256'(0));
        tick();
        start_i = 1'b0; wr_valid_i = 1'b0;
        check("start_vs_wr_busy", 256'(busy_o), 256'(1));
        serve_run(1'b0, 2);

        // Reset in the middle of a forward pass, right after round 4 is taken.
        start_pass(1'b0);
        key_ready_i = 1'b1;
        cyc = 0;
        while (round_o != 4'd4 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("mid_reach_round4", 256'(round_o), 256'(4));
        tick();
        rst = 1'b1;
        key_ready_i = 1'b0;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 256'(key_valid_o), 256'(0));
        check("mid_rst_loaded", 256'(loaded_o), 256'(0));
        check("mid_rst_wr_ready", 256'(wr_ready_o), 256'(1));
        check("mid_rst_busy", 256'(busy_o), 256'(0));
        check("mid_rst_key", 256'(key_o), 256'(0));

        // Random-mask keys loaded, then reloaded from IDLE; start ignored mid-reload.
        load_all(1'b1, -1);
        load_all(1'b1, 3);
        start_pass(1'b1);
        serve_run(1'b1, 2);
        start_pass(1'b0);
        serve_run(1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
